// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the two-port SPI SRAM arbiter.
package sram_port_arbiter_pkg;

   localparam int DEFAULT_WORD_WIDTH    = 16;
   localparam int DEFAULT_ADDRESS_WIDTH = 15;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   typedef enum logic [2:0] {
      ARB_IDLE      = 3'd0,
      ARB_ISSUE     = 3'd1,
      ARB_WAIT_RISE = 3'd2,
      ARB_WAIT_FALL = 3'd3,
      ARB_DONE      = 3'd4
   } arb_state_e;

   // Increment that sticks at the limit instead of wrapping.
   function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
      return (value >= limit) ? limit : value + 4'd1;
   endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester ports A/B plus the encoder-facing signals of the arbiter.
interface sram_port_arbiter_if
   import sram_port_arbiter_pkg::*;
#(
   parameter int WORD_WIDTH    = DEFAULT_WORD_WIDTH,
   parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) ();

   logic                     a_req;
   logic                     a_we;
   logic [ADDRESS_WIDTH-1:0] a_addr;
   logic [WORD_WIDTH-1:0]    a_wdata;
   logic [WORD_WIDTH-1:0]    a_rdata;
   logic                     a_done;

   logic                     b_req;
   logic                     b_we;
   logic [ADDRESS_WIDTH-1:0] b_addr;
   logic [WORD_WIDTH-1:0]    b_wdata;
   logic [WORD_WIDTH-1:0]    b_rdata;
   logic                     b_done;

   logic                     enc_initialized;
   logic                     enc_busy;
   logic [WORD_WIDTH-1:0]    enc_data_in;
   logic                     enc_request;
   logic [ADDRESS_WIDTH-1:0] enc_address;
   logic                     enc_write_enable;
   logic [WORD_WIDTH-1:0]    enc_data_out;
   logic                     grant_b;

   // Requesters and the encoder together form the master side.
   modport master (
      output a_req, a_we, a_addr, a_wdata,
      input  a_rdata, a_done,
      output b_req, b_we, b_addr, b_wdata,
      input  b_rdata, b_done,
      output enc_initialized, enc_busy, enc_data_in,
      input  enc_request, enc_address, enc_write_enable, enc_data_out, grant_b
   );

   // The arbiter itself.
   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      output a_rdata, a_done,
      input  b_req, b_we, b_addr, b_wdata,
      output b_rdata, b_done,
      input  enc_initialized, enc_busy, enc_data_in,
      output enc_request, enc_address, enc_write_enable, enc_data_out, grant_b
   );

endinterface

// File: rtl/sram_port_arbiter_arb_priority_select.sv
// Winner selection (A has priority) with a saturating count of A grants
// made while B waits, so B is forced through after MAX_CONSEC_A of them.
module arb_priority_select
   import sram_port_arbiter_pkg::*;
#(
   parameter int MAX_CONSEC_A = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic a_req,
   input  logic b_req,
   input  logic in_idle,
   input  logic grant,
   output logic sel_b
);

   localparam logic [3:0] MAX_C = 4'(MAX_CONSEC_A);

   logic [3:0] consec_a_q;
   logic [3:0] consec_a_d;

   // B wins only when A is absent or A has used up its consecutive budget.
   always_comb begin
      sel_b = b_req && (!a_req || (consec_a_q == MAX_C));
   end

   // Count A grants against a pending B; any B grant or idle cycle without B clears.
   always_comb begin
      consec_a_d = consec_a_q;
      if (in_idle) begin
         if (grant && sel_b) begin
            consec_a_d = '0;
         end else if (!b_req) begin
            consec_a_d = '0;
         end else if (grant) begin
            consec_a_d = sat_inc(consec_a_q, MAX_C);
         end
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         consec_a_q <= '0;
      end else begin
         consec_a_q <= consec_a_d;
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SPI SRAM encoder between requesters A and B: latches the
// winner's command, pulses the encoder request (reissuing it if busy never
// rises), waits out the busy window and returns read data with a done pulse.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int WORD_WIDTH    = DEFAULT_WORD_WIDTH,
   parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
   parameter int MAX_CONSEC_A  = 4,
   parameter int BUSY_WAIT     = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   sram_port_arbiter_if.slave bus
);

   localparam logic [2:0] BUSY_WAIT_C = 3'(BUSY_WAIT);

   arb_state_e               state_q;
   arb_state_e               state_d;
   logic [2:0]               retry_q;
   logic [2:0]               retry_d;
   logic                     grant_b_q;
   logic                     grant_b_d;
   logic [ADDRESS_WIDTH-1:0] enc_address_q;
   logic [ADDRESS_WIDTH-1:0] enc_address_d;
   logic                     enc_we_q;
   logic                     enc_we_d;
   logic [WORD_WIDTH-1:0]    enc_data_out_q;
   logic [WORD_WIDTH-1:0]    enc_data_out_d;
   logic [WORD_WIDTH-1:0]    a_rdata_q;
   logic [WORD_WIDTH-1:0]    a_rdata_d;
   logic [WORD_WIDTH-1:0]    b_rdata_q;
   logic [WORD_WIDTH-1:0]    b_rdata_d;

   logic in_idle;
   logic grant_fire;
   logic sel_b;
   logic retry_last;

   assign in_idle    = (state_q == ARB_IDLE);
   assign grant_fire = in_idle && bus.enc_initialized && !bus.enc_busy && (bus.a_req || bus.b_req);
   assign retry_last = ((retry_q + 3'd1) == BUSY_WAIT_C);

   arb_priority_select #(
      .MAX_CONSEC_A (MAX_CONSEC_A)
   ) u_priority_select (
      .clk     (clk),
      .reset_n (reset_n),
      .a_req   (bus.a_req),
      .b_req   (bus.b_req),
      .in_idle (in_idle),
      .grant   (grant_fire),
      .sel_b   (sel_b)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: grant, pulse, wait for busy to rise (or retry), wait for it to fall.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: begin
            if (grant_fire) state_d = ARB_ISSUE;
         end
         ARB_ISSUE: begin
            state_d = ARB_WAIT_RISE;
         end
         ARB_WAIT_RISE: begin
            if (bus.enc_busy) begin
               state_d = ARB_WAIT_FALL;
            end else if (retry_last) begin
               state_d = ARB_ISSUE;
            end
         end
         ARB_WAIT_FALL: begin
            if (!bus.enc_busy) state_d = ARB_DONE;
         end
         ARB_DONE: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // FSM outputs: request pulse and the winner's done pulse are pure state decodes.
   always_comb begin
      bus.enc_request = (state_q == ARB_ISSUE);
      bus.a_done      = (state_q == ARB_DONE) && (grant_b_q == PORT_A);
      bus.b_done      = (state_q == ARB_DONE) && (grant_b_q == PORT_B);
   end

   // Datapath next values: latch command on grant, count retries, capture read data.
   always_comb begin
      retry_d        = retry_q;
      grant_b_d      = grant_b_q;
      enc_address_d  = enc_address_q;
      enc_we_d       = enc_we_q;
      enc_data_out_d = enc_data_out_q;
      a_rdata_d      = a_rdata_q;
      b_rdata_d      = b_rdata_q;
      case (state_q)
         ARB_IDLE: begin
            if (grant_fire) begin
               grant_b_d = sel_b ? PORT_B : PORT_A;
               if (sel_b) begin
                  enc_address_d  = bus.b_addr;
                  enc_we_d       = bus.b_we;
                  enc_data_out_d = bus.b_wdata;
               end else begin
                  enc_address_d  = bus.a_addr;
                  enc_we_d       = bus.a_we;
                  enc_data_out_d = bus.a_wdata;
               end
            end
         end
         ARB_ISSUE: begin
            retry_d = '0;
         end
         ARB_WAIT_RISE: begin
            if (!bus.enc_busy) retry_d = retry_q + 3'd1;
         end
         ARB_WAIT_FALL: begin
            if (!bus.enc_busy && !enc_we_q) begin
               if (grant_b_q == PORT_B) begin
                  b_rdata_d = bus.enc_data_in;
               end else begin
                  a_rdata_d = bus.enc_data_in;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         retry_q        <= '0;
         grant_b_q      <= 1'b0;
         enc_address_q  <= '0;
         enc_we_q       <= 1'b0;
         enc_data_out_q <= '0;
         a_rdata_q      <= '0;
         b_rdata_q      <= '0;
      end else begin
         retry_q        <= retry_d;
         grant_b_q      <= grant_b_d;
         enc_address_q  <= enc_address_d;
         enc_we_q       <= enc_we_d;
         enc_data_out_q <= enc_data_out_d;
         a_rdata_q      <= a_rdata_d;
         b_rdata_q      <= b_rdata_d;
      end
   end

   assign bus.enc_address      = enc_address_q;
   assign bus.enc_write_enable = enc_we_q;
   assign bus.enc_data_out     = enc_data_out_q;
   assign bus.a_rdata          = a_rdata_q;
   assign bus.b_rdata          = b_rdata_q;
   assign bus.grant_b          = grant_b_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: a behavioural SPI SRAM encoder, requester
// tasks that push expected transactions into per-port queues, and monitors
// that compare the encoder command and the done/rdata against those queues.
`timescale 1ns/1ps
module tb_sram_port_arbiter;
   import sram_port_arbiter_pkg::*;

   localparam int WW   = 16;
   localparam int AW   = 15;
   localparam int MAXA = 4;
   localparam int BW   = 3;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [WW-1:0] wdata;
      logic [WW-1:0] rdata;
   } txn_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   sram_port_arbiter_if #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) bus ();

   sram_port_arbiter #(
      .WORD_WIDTH    (WW),
      .ADDRESS_WIDTH (AW),
      .MAX_CONSEC_A  (MAXA),
      .BUSY_WAIT     (BW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endfunction

   // Initial SRAM image shared by the encoder model and the reference memory.
   function automatic logic [WW-1:0] seed(input int a);
      return (a == 'h10) ? 16'hBEEF : WW'(a * 40503 + 7);
   endfunction

   // ---------------- encoder model ----------------
   logic [WW-1:0] sram_wr [int];
   int   busy_len   = 4;
   int   rand_busy  = 0;
   int   ignore_req = 0;
   int   ign_done   = 0;
   int   busy_cnt   = 0;
   logic m_busy = 1'b0;
   logic [WW-1:0] m_rd = '0;
   logic [AW-1:0] m_addr = '0;
   logic m_we = 1'b0;
   logic [WW-1:0] m_data = '0;
   assign bus.enc_busy    = m_busy;
   assign bus.enc_data_in = m_rd;

   always @(posedge clk) begin
      if (busy_cnt > 0) begin
         if (busy_cnt == 1) begin
            m_busy <= 1'b0;
            if (m_we) sram_wr[int'(m_addr)] = m_data;
            else m_rd <= sram_wr.exists(int'(m_addr)) ? sram_wr[int'(m_addr)] : seed(int'(m_addr));
         end else begin
            m_rd <= WW'($urandom);
         end
         busy_cnt <= busy_cnt - 1;
      end else if (bus.enc_request) begin
         if (ign_done < ignore_req) begin
            ign_done <= ign_done + 1;
         end else begin
            m_busy   <= 1'b1;
            busy_cnt <= (rand_busy != 0) ? int'($urandom_range(1, 6)) : busy_len;
            m_addr   <= bus.enc_address;
            m_we     <= bus.enc_write_enable;
            m_data   <= bus.enc_data_out;
         end
      end
   end

   // ---------------- reference model / scoreboard ----------------
   logic [WW-1:0] ref_wr [int];
   txn_t exp_a[$];
   txn_t exp_b[$];
   logic [WW-1:0] last_a = '0;
   logic [WW-1:0] last_b = '0;
   int a_done_cnt = 0;
   int b_done_cnt = 0;
   int req_count  = 0;
   int req_times[$];
   int done_log[$];

   function automatic logic [WW-1:0] ref_rd(input logic [AW-1:0] addr);
      return ref_wr.exists(int'(addr)) ? ref_wr[int'(addr)] : seed(int'(addr));
   endfunction

   function automatic txn_t make_txn(input logic we, input logic [AW-1:0] addr, input logic [WW-1:0] wd);
      txn_t t;
      t.we    = we;
      t.addr  = addr;
      t.wdata = wd;
      t.rdata = ref_rd(addr);
      if (we) ref_wr[int'(addr)] = wd;
      return t;
   endfunction

   // Encoder-side monitor: every request must carry the granted port's pending command.
   always @(negedge clk) begin
      if (reset_n && bus.enc_request) begin
         req_count++;
         req_times.push_back(cyc);
         if (bus.grant_b) begin
            check("enc_req_b_pending", 32'(exp_b.size() != 0), 1);
            if (exp_b.size() != 0) begin
               check("enc_addr_b", 32'(bus.enc_address), 32'(exp_b[0].addr));
               check("enc_we_b", 32'(bus.enc_write_enable), 32'(exp_b[0].we));
               check("enc_data_b", 32'(bus.enc_data_out), 32'(exp_b[0].wdata));
            end
         end else begin
            check("enc_req_a_pending", 32'(exp_a.size() != 0), 1);
            if (exp_a.size() != 0) begin
               check("enc_addr_a", 32'(bus.enc_address), 32'(exp_a[0].addr));
               check("enc_we_a", 32'(bus.enc_write_enable), 32'(exp_a[0].we));
               check("enc_data_a", 32'(bus.enc_data_out), 32'(exp_a[0].wdata));
            end
         end
      end
   end

   // Completion monitor: pop the port's oldest transaction and check both rdata registers.
   always @(negedge clk) begin
      txn_t t;
      if (reset_n && bus.a_done) begin
         a_done_cnt++;
         done_log.push_back(0);
         check("a_done_queue", 32'(exp_a.size() != 0), 1);
         if (exp_a.size() != 0) begin
            t = exp_a.pop_front();
            if (!t.we) last_a = t.rdata;
            check("a_rdata", 32'(bus.a_rdata), 32'(last_a));
            check("b_rdata_untouched", 32'(bus.b_rdata), 32'(last_b));
         end
      end
      if (reset_n && bus.b_done) begin
         b_done_cnt++;
         done_log.push_back(1);
         check("b_done_queue", 32'(exp_b.size() != 0), 1);
         if (exp_b.size() != 0) begin
            t = exp_b.pop_front();
            if (!t.we) last_b = t.rdata;
            check("b_rdata", 32'(bus.b_rdata), 32'(last_b));
            check("a_rdata_untouched", 32'(bus.a_rdata), 32'(last_a));
         end
      end
   end

   // ---------------- requester helpers ----------------
   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_done(input int port, output int ok);
      ok = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if ((port == 0 && bus.a_done) || (port == 1 && bus.b_done)) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic wait_req(output int ok);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.enc_request) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic push_a(input logic we, input logic [AW-1:0] addr, input logic [WW-1:0] wd);
      exp_a.push_back(make_txn(we, addr, wd));
      bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
   endtask

   task automatic push_b(input logic we, input logic [AW-1:0] addr, input logic [WW-1:0] wd);
      exp_b.push_back(make_txn(we, addr, wd));
      bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
   endtask

   task automatic a_txn(input logic we, input logic [AW-1:0] addr, input logic [WW-1:0] wd, input bit keep);
      int ok;
      push_a(we, addr, wd);
      bus.a_req = 1'b1;
      wait_done(0, ok);
      check("a_done_wait", 32'(ok), 1);
      if (!keep) bus.a_req = 1'b0;
   endtask

   task automatic b_txn(input logic we, input logic [AW-1:0] addr, input logic [WW-1:0] wd, input bit keep);
      int ok;
      push_b(we, addr, wd);
      bus.b_req = 1'b1;
      wait_done(1, ok);
      check("b_done_wait", 32'(ok), 1);
      if (!keep) bus.b_req = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_enc_request"}, 32'(bus.enc_request), 0);
      check({tag, "_enc_address"}, 32'(bus.enc_address), 0);
      check({tag, "_enc_we"}, 32'(bus.enc_write_enable), 0);
      check({tag, "_enc_data_out"}, 32'(bus.enc_data_out), 0);
      check({tag, "_a_rdata"}, 32'(bus.a_rdata), 0);
      check({tag, "_b_rdata"}, 32'(bus.b_rdata), 0);
      check({tag, "_a_done"}, 32'(bus.a_done), 0);
      check({tag, "_b_done"}, 32'(bus.b_done), 0);
      check({tag, "_grant_b"}, 32'(bus.grant_b), 0);
   endtask

   // Watchdog: a hang is reported and ends the run.
   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // ---------------- directed and random sequences ----------------
   initial begin
      int r0, d0, ok;
      reset_n = 1'b0;
      bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
      bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
      bus.enc_initialized = 1'b1;
      @(posedge clk); #2;
      check_all_zero("reset");
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      settle();

      // Single A read with a long busy window.
      busy_len = 20;
      r0 = req_count; d0 = a_done_cnt;
      a_txn(1'b0, 15'h0010, 16'h1111, 1'b0);
      settle(); settle();
      check("single_req_count", 32'(req_count - r0), 1);
      check("single_a_rdata", 32'(bus.a_rdata), 32'h0000BEEF);
      check("single_b_rdata", 32'(bus.b_rdata), 0);
      check("single_a_done_count", 32'(a_done_cnt - d0), 1);

      // Contention: both held high; B must break through after MAXA A grants.
      busy_len = 3;
      done_log.delete();
      @(negedge clk);
      fork
         begin
            for (int i = 0; i < 8; i++)
               a_txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), WW'($urandom), (i < 7));
         end
         begin
            for (int i = 0; i < 2; i++)
               b_txn(1'b1, AW'(16'h4000 + $urandom_range(0, 15)), WW'($urandom), (i < 1));
         end
      join
      settle();
      check("contention_len", 32'(done_log.size()), 10);
      for (int i = 0; i < 10 && i < done_log.size(); i++)
         check($sformatf("grant_order_%0d", i), 32'(done_log[i]), (i == 4 || i == 9) ? 1 : 0);

      // Busy never rises for the first two requests.
      busy_len = 2;
      ignore_req = ign_done + 2;
      req_times.delete();
      r0 = req_count; d0 = a_done_cnt;
      @(negedge clk);
      a_txn(1'b1, 15'h0020, 16'hA5A5, 1'b0);
      settle(); settle();
      check("retry_req_count", 32'(req_count - r0), 3);
      for (int i = 1; i < req_times.size() && i < 3; i++)
         check($sformatf("retry_spacing_%0d", i), 32'(req_times[i] - req_times[i-1]), BW + 1);
      check("retry_done_count", 32'(a_done_cnt - d0), 1);
      @(negedge clk);
      a_txn(1'b0, 15'h0020, 16'h0000, 1'b0);
      settle();
      check("retry_readback", 32'(bus.a_rdata), 32'h0000A5A5);

      // Encoder not initialized: no request until it comes up.
      bus.enc_initialized = 1'b0;
      r0 = req_count; d0 = a_done_cnt;
      push_a(1'b0, 15'h0030, 16'h0);
      bus.a_req = 1'b1;
      repeat (50) settle();
      check("noinit_no_request", 32'(req_count - r0), 0);
      bus.enc_initialized = 1'b1;
      ok = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (bus.enc_request) ok = 1;
      end
      check("noinit_request_after_init", 32'(ok), 1);
      wait_done(0, ok);
      check("noinit_done_wait", 32'(ok), 1);
      bus.a_req = 1'b0;
      settle();
      check("noinit_done_count", 32'(a_done_cnt - d0), 1);

      // Asynchronous reset while a B read is waiting for busy to fall.
      busy_len = 20;
      d0 = b_done_cnt;
      @(negedge clk);
      push_b(1'b0, 15'h4040, 16'h0);
      bus.b_req = 1'b1;
      wait_req(ok);
      check("reset_b_req_seen", 32'(ok), 1);
      repeat (5) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_all_zero("midreset");
      bus.b_req = 1'b0;
      exp_b.delete();
      last_a = '0;
      last_b = '0;
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      a_txn(1'b0, 15'h0010, 16'h0, 1'b0);
      repeat (30) settle();
      check("reset_no_b_done", 32'(b_done_cnt - d0), 0);
      check("reset_fresh_a_rdata", 32'(bus.a_rdata), 32'h0000BEEF);

      // Requester drops its request right after the issue.
      busy_len = 6;
      r0 = req_count; d0 = a_done_cnt;
      @(negedge clk);
      push_a(1'b0, 15'h0011, 16'h0);
      bus.a_req = 1'b1;
      wait_req(ok);
      check("drop_req_seen", 32'(ok), 1);
      bus.a_req = 1'b0;
      wait_done(0, ok);
      check("drop_done_wait", 32'(ok), 1);
      repeat (20) settle();
      check("drop_req_count", 32'(req_count - r0), 1);
      check("drop_done_count", 32'(a_done_cnt - d0), 1);

      // Random traffic on both ports with random encoder latency.
      rand_busy = 1;
      @(negedge clk);
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               a_txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), WW'($urandom), 1'b0);
            end
         end
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               b_txn(1'($urandom_range(0, 1)), AW'(16'h4000 + $urandom_range(0, 15)), WW'($urandom), 1'b0);
            end
         end
      join
      rand_busy = 0;
      repeat (10) settle();
      check("random_a_queue_empty", 32'(exp_a.size()), 0);
      check("random_b_queue_empty", 32'(exp_b.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one spi_sram_encoder instance between two requesters: port A (Hack CPU data/fetch side) and port B (ROM stream loader or a VRAM side-channel).
- Registers each requester's command, pulses the encoder's single-cycle request, tracks busy, and returns read data with a done pulse.
- Port A has fixed priority, with an anti-starvation limit so B is always serviced.
- Sits between the requester logic and the encoder, in the clk domain.

Parameters:
- WORD_WIDTH, 16, data width of both ports and the encoder.
- ADDRESS_WIDTH, 15, address width of both ports and the encoder.
- MAX_CONSEC_A, 4, maximum back-to-back A grants while B is pending (legal range 1..15).
- BUSY_WAIT, 3, clk cycles allowed after enc_request for enc_busy to rise before the request is reissued (legal range 1..7).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- a_req  in  1  level; held high until a_done
- a_we  in  1  1 = write, 0 = read
- a_addr  in  ADDRESS_WIDTH  word address
- a_wdata  in  WORD_WIDTH  write data
- a_rdata  out  WORD_WIDTH  read data; valid from a_done until the next A read completes
- a_done  out  1  1-cycle completion pulse
- b_req, b_we, b_addr, b_wdata, b_rdata, b_done: same as port A, for port B
- enc_initialized  in  1  encoder init sequence finished
- enc_busy  in  1  encoder transaction in progress
- enc_data_in  in  WORD_WIDTH  read data from encoder
- enc_request  out  1  1-cycle request pulse
- enc_address  out  ADDRESS_WIDTH  registered address
- enc_write_enable  out  1  registered write flag
- enc_data_out  out  WORD_WIDTH  registered write data
- grant_b  out  1  1 while the current or last transaction belongs to B

Behaviour:
- Reset (async, reset_n=0):
  - Registered outputs: all zero.
  - State: IDLE; consecutive counter: 0; retry counter: 0; grant_b: 0.
  - Reset mid-transaction abandons it; no done pulse is issued.
- FSM states: IDLE, ISSUE, WAIT_RISE, WAIT_FALL, DONE.
- IDLE:
  - Waits for enc_initialized=1, enc_busy=0, and (a_req or b_req).
  - Selects B if b_req and (!a_req or consec_a==MAX_CONSEC_A); otherwise selects A.
  - Latches addr/we/wdata of the winner into enc_* registers, sets grant_b, then goes to ISSUE.
- ISSUE:
  - enc_request=1 for exactly this cycle.
  - Clears the retry counter, then goes to WAIT_RISE.
- WAIT_RISE:
  - enc_busy=1 -> WAIT_FALL.
  - Otherwise the retry counter increments.
  - At BUSY_WAIT -> ISSUE, which reissues the request with the same latched command.
- WAIT_FALL:
  - enc_busy=0 -> DONE.
  - On a read, enc_data_in is captured into the winner's rdata register on this transition.
- DONE:
  - Pulses the winner's done for 1 cycle, then returns to IDLE.
  - Minimum turnaround from req to done is 4 cycles plus encoder busy time.
- Anti-starvation counter:
  - consec_a increments on each A grant while b_req=1.
  - It clears on any B grant, and in any cycle in IDLE where b_req=0.
  - It saturates at MAX_CONSEC_A.
- Requester drops req mid-transaction: the transaction still completes and done still pulses; the requester ignores it.
- Simultaneous a_req and b_req in IDLE with consec_a < MAX: A wins.
- The done cycle and a new req may coincide. The arbiter re-arbitrates in the next IDLE cycle, and the requester must sample its own done before re-requesting.
- enc_initialized falls:
  - No new grants are made.
  - A transaction already in flight proceeds per busy.
- enc_* outputs stay stable from IDLE exit until the next grant.
- rdata of the non-winning port is never modified.

Decomposition:
- Shared package/include: state encodings (ARB_IDLE..ARB_DONE), port index constants PORT_A=0 and PORT_B=1, and the default WORD_WIDTH/ADDRESS_WIDTH (taken from the project params include).
- Sub-module arb_priority_select (combinational winner select plus the saturating consec_a counter) is natural. The FSM and the datapath registers stay in the top.

Test Plan:
- Single A read:
  - Stimulus: enc_initialized=1, a_req=1, a_we=0, a_addr=0x0010; encoder model holds busy for 20 cycles and returns 0xBEEF.
  - Required: one enc_request pulse with enc_address=0x0010; a_rdata=0xBEEF; a_done pulses once; b_rdata unchanged (0).
- Contention:
  - Stimulus: a_req and b_req held high continuously with MAX_CONSEC_A=4.
  - Required: grant order A,A,A,A,B,A,A,A,A,B; every B write reaches enc_data_out with the correct b_wdata.
- Busy never rises:
  - Stimulus: encoder ignores the first 2 requests.
  - Required: enc_request reissued every BUSY_WAIT+1 cycles with identical address and data; the third succeeds; exactly one done.
- Not initialized:
  - Stimulus: enc_initialized=0 for 50 cycles with a_req=1.
  - Required: no enc_request during those cycles; first enc_request within 2 cycles of enc_initialized rising.
- Async reset in WAIT_FALL:
  - Stimulus: reset_n=0 for 1 cycle during a B read.
  - Required: all outputs 0 immediately, no b_done; a fresh a_req afterwards completes normally.
- Requester drops req after ISSUE:
  - Stimulus: a_req falls after the request is issued.
  - Required: transaction completes; a_done pulses once; FSM returns to IDLE with no new request.
